// File: rtl/ahb3lite_sram_slave_if.sv
// AHB-Lite bus bundle between a master (or bus fabric) and the SRAM slave.
// Address/control: HSEL HADDR HWRITE HSIZE HBURST HTRANS HREADY
// Write data     : HWDATA
// Slave response : HREADYOUT HRESP HRDATA HRDATA_En
interface ahb3lite_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        HRDATA_En;

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA, HRDATA_En
  );

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA, HRDATA_En
  );
endinterface

// File: rtl/ahb3lite_sram_slave.sv
// AHB-Lite slave in front of a DEPTH x 32-bit register-array memory.
// Handles SINGLE/INCR word transfers with WAIT_STATES wait cycles per OKAY
// data phase and a two-cycle ERROR response for illegal transfers.
// Ports:
//   HCLK   - bus clock, rising-edge
//   HRESET - asynchronous active-high reset
//   ahb    - slave modport: HSEL/HADDR/HWRITE/HSIZE/HBURST/HTRANS/HWDATA/HREADY
//            in; HREADYOUT/HRESP/HRDATA/HRDATA_En out (all registered)
// Build option: define AHB_SLV_RANGE_CHECK_EN to answer HADDR >= DEPTH with
// ERROR; otherwise the word index wraps modulo DEPTH.
module ahb3lite_sram_slave #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                  HCLK,
  input logic                  HRESET,
  ahb3lite_sram_slave_if.slave ahb
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [2:0]  SIZE_WORD = 3'b010;
  localparam logic [3:0]  WS_INIT   =
    4'((WAIT_STATES == 32'd0) ? 32'd0 : WAIT_STATES - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic            hreadyout_q, hreadyout_d;
  logic            hresp_q, hresp_d;
  logic [31:0]     hrdata_q, hrdata_d;
  logic            hrdata_en_q, hrdata_en_d;
  logic [31:0]     mem [DEPTH];

  logic accept_c, err_c, range_err_c, fwd_c;
  logic unused_bits;

  // HBURST is informational only; upper address bits matter only with range checking
  assign unused_bits = ^{ahb.HBURST, ahb.HADDR[31:AW]};

`ifdef AHB_SLV_RANGE_CHECK_EN
  assign range_err_c = |ahb.HADDR[31:AW];
`else
  assign range_err_c = 1'b0;
`endif

  // New address phases are taken only when no data phase is stalling
  assign accept_c = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] &
                    ((state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2));
  assign err_c    = (ahb.HSIZE != SIZE_WORD) | range_err_c;

  // A pipelined read of the word being written this cycle sees the new data
  assign fwd_c = (state_q == S_DATA) && write_q && (addr_q == addr_d);

  // State and output registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      hrdata_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      hrdata_en_q <= hrdata_en_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all finish their cycle ready for a new transfer
        state_d = S_IDLE;
        if (accept_c) begin
          addr_d  = ahb.HADDR[AW-1:0];
          write_d = ahb.HWRITE;
          if (err_c) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES != 32'd0) begin
            state_d = S_WAIT;
            cnt_d   = WS_INIT;
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  // Output logic: values presented during the cycle spent in state_d
  always_comb begin
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    hrdata_en_d = 1'b0;
    hrdata_d    = hrdata_q;
    case (state_d)
      S_WAIT: hreadyout_d = 1'b0;
      S_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b1;
      end
      S_ERR2: hresp_d = 1'b1;
      S_DATA: begin
        if (!write_d) begin
          hrdata_en_d = 1'b1;
          hrdata_d    = fwd_c ? ahb.HWDATA : mem[addr_d];
        end
      end
      default: ;
    endcase
  end

  // Write lands at the end of the DATA cycle; reset forces IDLE so a pending write is dropped
  always_ff @(posedge HCLK) begin
    if ((state_q == S_DATA) && write_q) mem[addr_q] <= ahb.HWDATA;
  end

  assign ahb.HREADYOUT = hreadyout_q;
  assign ahb.HRESP     = hresp_q;
  assign ahb.HRDATA    = hrdata_q;
  assign ahb.HRDATA_En = hrdata_en_q;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Bench for ahb3lite_sram_slave: one instance with 0 and one with 2 wait
// states share a pipelined AHB-Lite master; a scoreboard queue holds the
// expected response of every accepted transfer until its data phase ends.
module tb_ahb3lite_sram_slave;

  localparam logic [2:0] WORD = 3'b010;
  localparam logic [2:0] HALF = 3'b001;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR = 3'b001;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
`ifdef AHB_SLV_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  ahb3lite_sram_slave_if ifc0 ();
  ahb3lite_sram_slave_if ifc1 ();

  ahb3lite_sram_slave #(.DEPTH(64), .WAIT_STATES(0)) dut0 (.HCLK(HCLK), .HRESET(HRESET), .ahb(ifc0.slave));
  ahb3lite_sram_slave #(.DEPTH(64), .WAIT_STATES(2)) dut1 (.HCLK(HCLK), .HRESET(HRESET), .ahb(ifc1.slave));

  logic        m_sel, m_dut, m_write, ext_stall, dp_dut;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_size, m_burst;
  logic [1:0]  m_trans;
  logic        hready_m, hresp_m, hrdata_en_m, bus_ready;
  logic [31:0] hrdata_m;

  assign ifc0.HSEL = m_sel & ~m_dut;
  assign ifc1.HSEL = m_sel & m_dut;
  assign {ifc0.HADDR, ifc1.HADDR} = {m_addr, m_addr};
  assign {ifc0.HWRITE, ifc1.HWRITE} = {m_write, m_write};
  assign {ifc0.HSIZE, ifc1.HSIZE} = {m_size, m_size};
  assign {ifc0.HBURST, ifc1.HBURST} = {m_burst, m_burst};
  assign {ifc0.HTRANS, ifc1.HTRANS} = {m_trans, m_trans};
  assign {ifc0.HWDATA, ifc1.HWDATA} = {m_wdata, m_wdata};
  // Response mux follows the slave owning the current data phase
  assign hready_m    = dp_dut ? ifc1.HREADYOUT : ifc0.HREADYOUT;
  assign hresp_m     = dp_dut ? ifc1.HRESP     : ifc0.HRESP;
  assign hrdata_m    = dp_dut ? ifc1.HRDATA    : ifc0.HRDATA;
  assign hrdata_en_m = dp_dut ? ifc1.HRDATA_En : ifc0.HRDATA_En;
  assign bus_ready   = hready_m & ~ext_stall;
  assign {ifc0.HREADY, ifc1.HREADY} = {bus_ready, bus_ready};

  typedef struct {
    logic dut; logic rd; logic err; logic [31:0] exp; int tag;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic dut; logic sel; logic [1:0] trans; logic wr; logic [31:0] addr;
    logic [2:0] size; logic [31:0] wdata; logic exp_err; logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl[$];

  int checks = 0;
  int errors = 0;
  int tag = 0;
  int wcnt = 0;
  int dp_cycles = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (xfer %0d): got %h, expected %h", nm, t, act, exp);
    end
  endtask

  // Data-phase monitor: wait cycles, then the completing cycle, or an idle bus
  always @(negedge HCLK) begin
    if (mon_en && !HRESET) begin
      if (sbq.size() != 0) begin
        dp_cycles++;
        if (!hready_m) begin
          wcnt++;
          chk("stall hresp", sbq[0].tag, 32'(hresp_m), 32'(sbq[0].err));
          chk("stall hrdata_en", sbq[0].tag, 32'(hrdata_en_m), 32'd0);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("hresp", e.tag, 32'(hresp_m), 32'(e.err));
          chk("hrdata_en", e.tag, 32'(hrdata_en_m), 32'(e.rd & ~e.err));
          if (e.rd && !e.err) chk("hrdata", e.tag, hrdata_m, e.exp);
          chk("wait cycles", e.tag, 32'(wcnt), e.err ? 32'd1 : (e.dut ? 32'd2 : 32'd0));
          wcnt = 0;
        end
      end else begin
        chk("idle hreadyout", -1, 32'(hready_m), 32'd1);
        chk("idle hresp", -1, 32'(hresp_m), 32'd0);
        chk("idle hrdata_en", -1, 32'(hrdata_en_m), 32'd0);
      end
    end
  end

  task automatic add(input logic dut, input logic sel, input logic [1:0] trans, input logic wr,
                     input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata,
                     input logic exp_err, input logic [31:0] exp_rd);
    vec_t v;
    v.dut = dut; v.sel = sel; v.trans = trans; v.wr = wr; v.addr = addr;
    v.size = size; v.wdata = wdata; v.exp_err = exp_err; v.exp_rd = exp_rd;
    tbl.push_back(v);
  endtask

  // Present one address phase and wait (bounded) until it is accepted
  task automatic xfer(input logic dut, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [1:0] trans, input logic [2:0] burst, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rd);
    int n;
    logic rdy;
    sb_t e;
    m_sel = 1'b1; m_dut = dut; m_write = wr; m_addr = addr;
    m_size = size; m_trans = trans; m_burst = burst;
    n = 0;
    do begin
      @(negedge HCLK); rdy = bus_ready;
      @(posedge HCLK); n++;
    end while (!rdy && n < 50);
    chk("accept timeout", tag, 32'(rdy), 32'd1);
    #1;
    m_wdata = wdata;
    dp_dut  = dut;
    e.dut = dut; e.rd = ~wr; e.err = exp_err; e.exp = exp_rd; e.tag = tag;
    sbq.push_back(e);
    tag++;
  endtask

  task automatic bus_idle();
    int n;
    m_sel = 1'b0; m_trans = IDLE;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(posedge HCLK); n++;
    end
    chk("drain timeout", tag, 32'(sbq.size()), 32'd0);
    @(posedge HCLK); #1;
  endtask

  task automatic check_reset();
    chk("rst hreadyout0", -1, 32'(ifc0.HREADYOUT), 32'd1);
    chk("rst hresp0", -1, 32'(ifc0.HRESP), 32'd0);
    chk("rst hrdata0", -1, ifc0.HRDATA, 32'd0);
    chk("rst hrdata_en0", -1, 32'(ifc0.HRDATA_En), 32'd0);
    chk("rst hreadyout1", -1, 32'(ifc1.HREADYOUT), 32'd1);
    chk("rst hresp1", -1, 32'(ifc1.HRESP), 32'd0);
    chk("rst hrdata1", -1, ifc1.HRDATA, 32'd0);
    chk("rst hrdata_en1", -1, 32'(ifc1.HRDATA_En), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1; m_sel = 1'b0; m_dut = 1'b0; m_write = 1'b0; m_addr = '0;
    m_size = WORD; m_burst = SINGLE; m_trans = IDLE; m_wdata = '0;
    ext_stall = 1'b0; dp_dut = 1'b0;

    //   dut sel trans wr  addr           size  wdata          err  expected read
    add(0, 1, NSEQ, 1, 32'd5,  WORD, 32'hDEADBEEF, 0, 32'h0);
    add(0, 1, NSEQ, 0, 32'd5,  WORD, 32'h0,        0, 32'hDEADBEEF);
    add(0, 1, NSEQ, 1, 32'd3,  WORD, 32'h00000011, 0, 32'h0);
    add(0, 1, IDLE, 0, 32'd3,  WORD, 32'h0,        0, 32'h0);
    add(0, 1, BUSY, 0, 32'd3,  WORD, 32'h0,        0, 32'h0);
    add(0, 1, NSEQ, 1, 32'd3,  WORD, 32'h00000055, 0, 32'h0);
    add(0, 1, NSEQ, 0, 32'd3,  WORD, 32'h0,        0, 32'h00000055);
    add(0, 1, NSEQ, 0, 32'd3,  HALF, 32'h0,        1, 32'h0);
    add(0, 1, NSEQ, 0, 32'd5,  WORD, 32'h0,        0, 32'hDEADBEEF);
    add(0, 0, NSEQ, 0, 32'd5,  WORD, 32'h0,        0, 32'h0);
    add(0, 1, NSEQ, 1, 32'd0,  WORD, 32'hA5A5A5A5, 0, 32'h0);
    add(0, 1, NSEQ, 1, 32'd64, WORD, 32'h12345678, RC, 32'h0);
    add(0, 1, NSEQ, 0, 32'd0,  WORD, 32'h0,        0, RC ? 32'hA5A5A5A5 : 32'h12345678);
    add(0, 1, NSEQ, 0, 32'd64, WORD, 32'h0,        RC, 32'h12345678);
    add(0, 1, NSEQ, 1, 32'd3,  HALF, 32'h00000BAD, 1, 32'h0);
    add(0, 1, NSEQ, 0, 32'd3,  WORD, 32'h0,        0, 32'h00000055);
    add(1, 1, NSEQ, 1, 32'd10, WORD, 32'd1,        0, 32'h0);
    add(1, 1, NSEQ, 1, 32'd9,  WORD, 32'd2,        0, 32'h0);
    add(1, 1, NSEQ, 1, 32'd8,  WORD, 32'd3,        0, 32'h0);
    add(1, 1, NSEQ, 1, 32'd7,  WORD, 32'd4,        0, 32'h0);
    add(1, 1, NSEQ, 1, 32'd20, WORD, 32'h11111111, 0, 32'h0);
    add(1, 1, NSEQ, 0, 32'd20, WORD, 32'h0,        0, 32'h11111111);

    repeat (2) @(posedge HCLK);
    #1 check_reset();
    #1 HRESET = 1'b0;
    mon_en = 1'b1;
    @(posedge HCLK); #1;

    foreach (tbl[i]) begin
      if (tbl[i].sel && tbl[i].trans[1]) begin
        xfer(tbl[i].dut, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].trans, SINGLE,
             tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_rd);
      end else begin
        m_sel = tbl[i].sel; m_dut = tbl[i].dut; m_trans = tbl[i].trans;
        m_write = tbl[i].wr; m_addr = tbl[i].addr; m_size = tbl[i].size;
        @(posedge HCLK); #1;
      end
    end
    bus_idle();

    // Another slave stalls HREADY: a NONSEQ to dut0 must wait for it
    ext_stall = 1'b1;
    m_sel = 1'b1; m_dut = 1'b0; m_trans = NSEQ; m_write = 1'b0; m_addr = 32'd5; m_size = WORD;
    repeat (3) @(posedge HCLK);
    #1 ext_stall = 1'b0;
    xfer(0, 0, 32'd5, WORD, NSEQ, SINGLE, 32'h0, 0, 32'hDEADBEEF);
    bus_idle();

    // Decrementing INCR read burst on the 2-wait-state slave
    dp_cycles = 0;
    xfer(1, 0, 32'd10, WORD, NSEQ, INCR, 32'h0, 0, 32'd1);
    xfer(1, 0, 32'd9,  WORD, SEQ,  INCR, 32'h0, 0, 32'd2);
    xfer(1, 0, 32'd8,  WORD, SEQ,  INCR, 32'h0, 0, 32'd3);
    xfer(1, 0, 32'd7,  WORD, SEQ,  INCR, 32'h0, 0, 32'd4);
    bus_idle();
    chk("burst data-phase cycles", -1, 32'(dp_cycles), 32'd12);

    // Reset during the first wait cycle of a write: outputs clear at once, word 20 untouched
    xfer(1, 1, 32'd20, WORD, NSEQ, SINGLE, 32'h99999999, 0, 32'h0);
    m_sel = 1'b0; m_trans = IDLE;
    @(negedge HCLK);
    #2 HRESET = 1'b1;
    #1 check_reset();
    sbq.delete();
    wcnt = 0;
    repeat (2) @(posedge HCLK);
    #2 HRESET = 1'b0;
    @(posedge HCLK); #1;
    xfer(1, 0, 32'd20, WORD, NSEQ, SINGLE, 32'h0, 0, 32'h11111111);
    bus_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
